round_robin_arbiter: RTL
========================

ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 Parameter: WIDTH, default 4, number of request lines; SHALL be greater than one.
REQ-002 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 iv_req  input  WIDTH  request lines, one bit per requester, sampled every edge, any number set at once.
REQ-005 i_ack  input  1  consumer acknowledge; meaningful only while o_valid is high.
REQ-006 o_valid  output  1  grant valid, active HIGH.
REQ-007 ov_grant  output  WIDTH  grant vector; one-hot while o_valid high, all-zero otherwise.
REQ-008 ov_pending  output  WIDTH  registered pending-request vector.
REQ-009 ov_grant SHALL be directly consumable by the binary encoder stage: zero or exactly one bit set on every cycle.

Function
REQ-010 Pending: on each edge pending[i] SHALL be set when iv_req[i] is high; a set bit SHALL stay set until its grant is acknowledged.
REQ-011 States: IDLE, GRANT; reset state IDLE.
REQ-012 IDLE: if pending is non-zero at an edge, SHALL register a one-hot grant and move to GRANT; otherwise stay IDLE with ov_grant zero.
REQ-013 Selection: the granted bit SHALL be the first set pending bit searching upward from index (last_granted + 1) modulo WIDTH, wrapping past WIDTH-1 to 0.
REQ-014 Pointer last_granted SHALL reset to WIDTH-1, so the first grant after reset searches from index 0.
REQ-015 GRANT: o_valid high, ov_grant constant until an edge with i_ack high.
REQ-016 On the ack edge: pending bit of the granted line cleared, last_granted set to the granted index, state to IDLE, o_valid low the following cycle.
REQ-017 Simultaneous set and clear: if iv_req of the granted line is high on the ack edge, its pending bit SHALL remain set (set wins); it is then lowest priority under REQ-013.
REQ-018 Latency: request sampled at edge k -> pending visible after k -> o_valid high after edge k+1 (two-edge minimum).
REQ-019 After an ack, at least one cycle with o_valid low SHALL occur before the next grant (IDLE re-arbitrates at the next edge).
REQ-020 i_ack while IDLE SHALL be ignored; no state, pointer or pending change.
REQ-021 Requests arriving during GRANT SHALL only accumulate into pending; they SHALL NOT alter the current grant.
REQ-022 Fairness: with all lines continuously requesting, grants SHALL cycle 0,1,...,WIDTH-1,0,... with no line granted twice before every other requesting line.
REQ-023 All outputs SHALL be driven from registers; no combinational path from inputs to outputs.

Reset
REQ-024 Asserting i_rst_n low SHALL immediately, without a clock edge, force: state IDLE, o_valid 0, ov_grant 0, ov_pending 0, last_granted WIDTH-1.
REQ-025 Reset asserted mid-GRANT SHALL drop o_valid asynchronously and discard all pending requests.
REQ-026 After release, the first edge SHALL sample iv_req normally; no request held during reset is remembered.

Verification
REQ-027 WIDTH=4, single pulse iv_req=0100 one cycle -> ov_pending=0100 after edge 1, o_valid=1 and ov_grant=0100 after edge 2; hold i_ack=0 five cycles -> outputs unchanged; ack -> ov_pending=0000, o_valid=0.
REQ-028 WIDTH=4, iv_req=1111 held, i_ack=1 whenever o_valid -> grant sequence 0001,0010,0100,1000,0001, with one o_valid-low cycle between grants.
REQ-029 WIDTH=4, after grant 1000 acked, iv_req=0001 and 1000 pending -> next grant 0001 (wrap-around), then 1000.
REQ-030 WIDTH=4, granted 0010 with iv_req[1]=1 on the ack edge -> ov_pending bit 1 stays set; with 0100 also pending, next grant 0100 before 0010.
REQ-031 WIDTH=4, i_rst_n low mid-GRANT (ov_grant=0010, ov_pending=1010) between edges -> o_valid=0, ov_grant=0000, ov_pending=0000 immediately; after release with iv_req=0000 -> stays IDLE.
REQ-032 WIDTH=5, random iv_req/i_ack for 10000 cycles -> ov_grant never multi-hot, zero whenever o_valid low, and no pending line waits more than WIDTH grants.

Source files
------------

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter.
// Requests accumulate into a registered pending vector. When idle, the arbiter
// grants the first pending line found searching upward from one past the last
// acknowledged grant, wrapping around. The grant is held until acknowledged,
// then the arbiter drops o_valid for one cycle before re-arbitrating.
// Every output comes straight from a register.

module round_robin_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] iv_req,
    input  logic             i_ack,
    output logic             o_valid,
    output logic [WIDTH-1:0] ov_grant,
    output logic [WIDTH-1:0] ov_pending
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_valid;
    logic [WIDTH-1:0] r_grant;
    logic [WIDTH-1:0] r_pending;
    logic [IW-1:0]    r_grantIdx;
    logic [IW-1:0]    r_lastIdx;

    logic [IW-1:0]    w_selIdx;
    logic             w_found;
    int               w_cand;
    logic [WIDTH-1:0] w_clear;

    // Rotating search: the first pending line strictly after the last granted index.
    always_comb begin
        w_selIdx = '0;
        w_found  = 1'b0;
        w_cand   = 0;
        for (int off = 1; off <= WIDTH; off++) begin
            w_cand = int'(r_lastIdx) + off;
            if (w_cand >= WIDTH) begin
                w_cand = w_cand - WIDTH;
            end
            if (!w_found && r_pending[IW'(w_cand)]) begin
                w_found  = 1'b1;
                w_selIdx = IW'(w_cand);
            end
        end
    end

    // An acknowledge in GRANT retires the granted line; it is ignored when idle.
    always_comb begin
        w_clear = '0;
        if (r_state == GRANT && i_ack) begin
            w_clear = r_grant;
        end
    end

    // Pending vector: new requests OR in, and a request on the ack edge wins over the clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clear) | iv_req;
        end
    end

    // Grant FSM with registered valid/grant and the round-robin pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_valid    <= 1'b0;
            r_grant    <= '0;
            r_grantIdx <= '0;
            r_lastIdx  <= IW'(WIDTH - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state    <= GRANT;
                        r_valid    <= 1'b1;
                        r_grant    <= {{(WIDTH-1){1'b0}}, 1'b1} << w_selIdx;
                        r_grantIdx <= w_selIdx;
                    end
                end
                GRANT: begin
                    if (i_ack) begin
                        r_state   <= IDLE;
                        r_valid   <= 1'b0;
                        r_grant   <= '0;
                        r_lastIdx <= r_grantIdx;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign o_valid    = r_valid;
    assign ov_grant   = r_grant;
    assign ov_pending = r_pending;

endmodule
